cash_request_queue: RTL and testbench
=====================================

Name: cash_request_queue

Overview:
- Request buffer directly upstream of fast_unordered_cash.
- Accepts cache requests (action, address, data) from a producer over a valid/ready handshake and stores them in a first-word-fall-through FIFO.
- Presents the oldest request to the cache port, one request per out handshake.
- Decouples producer bursts from cache stalls.

Parameters:
- address_size, 4, width of request address (matches cache address_size)
- data_size, 4, width of request data (matches cache data_size)
- depth, 4, number of FIFO entries; power of two, >= 2

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- flush  input  1  discard all queued entries
- in_valid  input  1  producer request present
- in_ready  output  1  queue can accept (= !full)
- in_action  input  1  1 = write, 0 = read (same encoding as cache action)
- in_address  input  address_size  request address
- in_data  input  data_size  write data (ignored content for reads, still stored)
- out_valid  output  1  head entry present (= !empty)
- out_ready  input  1  cache consumes head this cycle
- out_action  output  1  head action
- out_address  output  address_size  head address
- out_data  output  data_size  head data
- count  output  $clog2(depth)+1  number of queued entries
- full  output  1  count == depth
- empty  output  1  count == 0

Behaviour:
- Storage: depth-entry register array; write pointer wp and read pointer rp, each $clog2(depth) bits, wrap modulo depth; count held in its own register.
- Reset (rst=1 at clk edge): wp=rp=0, count=0; thus empty=1, full=0, in_ready=1, out_valid=0. Array contents are not reset. out_action/out_address/out_data are don't-care while out_valid=0; the bench must not check them then.
- Push: occurs when in_valid && in_ready. Writes the entry at wp; wp increments.
- Pop: occurs when out_valid && out_ready. rp increments.
- count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Latency: an entry pushed at edge N appears on out_* after edge N. No same-cycle bypass from in_* to out_*.
- Outputs: out_* are driven combinationally from array[rp].
- Full boundary: in_ready=0, so no push even when a pop occurs in the same cycle. Ready is not allowed to depend on out_ready.
- Empty boundary: out_valid=0, so out_ready is ignored.
- Producer holding: in_valid may be held across a full condition. The request is accepted on the first cycle in_ready=1, and the producer must hold in_* stable until then.
- Wrap-around: pointers roll from depth-1 to 0 with no gap. Order is strictly FIFO across the wrap.
- Flush: synchronous, priority over push and pop in the same cycle. wp=rp=0, count=0; in-flight in_valid is dropped, not stored.
- Reset priority: rst has priority over flush and all handshakes. Reset mid-burst discards all entries; the first push after reset lands at index 0.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Optional Feature:
- Macro: CASH_REQ_MERGE_EN
- Defined (write merge):
  - A push merges into the most recently queued entry (index wp-1) instead of allocating, when all of these hold: in_action=1, the tail entry has action=1, same address, and the tail entry is not the head being popped this cycle.
  - On merge: the tail's data is overwritten with in_data; wp and count are unchanged.
  - Merge is allowed while full, so in_ready = !full || merge_hit.
- Undefined: every push allocates a new entry; in_ready = !full.

Test Plan:
- Reset then push 4 writes, addresses 1,2,3,4, data A,B,C,D, with out_ready=0 -> count=4, full=1, in_ready=0; then out_ready=1 -> pops 1/A,2/B,3/C,4/D on consecutive cycles, then empty=1.
- Wrap: push 3, pop 3, push 4 (addresses 5..8), drain -> order 5,6,7,8; count goes 4,3,2,1,0.
- With count=2, push and pop in the same cycle -> count stays 2, head advances, and the new entry becomes the tail.
- With count=4 and in_valid=1 held, pulse out_ready for 1 cycle -> push accepted on the following cycle only; no entry lost or duplicated.
- With count=3, assert flush together with in_valid=1 -> next cycle count=0, empty=1; the in-flight request is absent after later pushes. rst mid-burst behaves the same way.
- CASH_REQ_MERGE_EN: push write addr 9 data 3, then write addr 9 data 7 -> count=1, head 9/7. Same sequence with the macro undefined -> count=2.

Source files
------------

// File: rtl/cash_request_queue.sv
// FWFT request queue feeding fast_unordered_cash: valid/ready in, oldest entry out.
// Optional write merging into the tail entry is enabled by defining CASH_REQ_MERGE_EN.
module cash_request_queue #(
  parameter int address_size = 4,
  parameter int data_size    = 4,
  parameter int depth        = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_action,
  input  logic [address_size-1:0] in_address,
  input  logic [data_size-1:0]    in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_action,
  output logic [address_size-1:0] out_address,
  output logic [data_size-1:0]    out_data,
  output logic [$clog2(depth):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int PW = $clog2(depth);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(depth);

  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;

  logic                    mem_action_q  [depth];
  logic [address_size-1:0] mem_address_q [depth];
  logic [data_size-1:0]    mem_data_q    [depth];

  logic          push, pop, alloc, wr_en, merge_hit;
  logic [PW-1:0] wr_idx;

  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign out_valid   = !empty;
  assign out_action  = mem_action_q[rp_q];
  assign out_address = mem_address_q[rp_q];
  assign out_data    = mem_data_q[rp_q];

  assign pop = out_valid && out_ready;

`ifdef CASH_REQ_MERGE_EN
  logic [PW-1:0] tail_idx;
  logic          merge_cand;

  assign tail_idx   = wp_q - PW'(1);
  assign merge_cand = !empty && in_action && mem_action_q[tail_idx] &&
                      (mem_address_q[tail_idx] == in_address);
  // Tail equals head only when count==1; full implies count>=2, so ready never sees out_ready.
  assign merge_hit  = merge_cand && !(pop && (tail_idx == rp_q));
  assign in_ready   = !full || merge_cand;
`else
  assign merge_hit  = 1'b0;
  assign in_ready   = !full;
`endif

  assign push  = in_valid && in_ready;
  assign alloc = push && !merge_hit;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = wp_q;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      wr_en = push;
`ifdef CASH_REQ_MERGE_EN
      if (merge_hit) wr_idx = tail_idx;
`endif
      if (alloc) wp_d = wp_q + PW'(1);
      if (pop)   rp_d = rp_q + PW'(1);
      if (alloc && !pop)      count_d = count_q + CW'(1);
      else if (!alloc && pop) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Storage is never reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem_action_q[wr_idx]  <= in_action;
      mem_address_q[wr_idx] <= in_address;
      mem_data_q[wr_idx]    <= in_data;
    end
  end

endmodule

// File: tb/tb_cash_request_queue.sv
// Directed bench for cash_request_queue with a scoreboard monitor on the out port.
module tb_cash_request_queue;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, in_action, out_ready;
  logic [3:0] in_address, in_data;
  logic       in_ready, out_valid, out_action, full, empty;
  logic [3:0] out_address, out_data;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       a;
    logic [3:0] addr;
    logic [3:0] data;
  } req_t;

  req_t exp_q[$];

  cash_request_queue #(.address_size(4), .data_size(4), .depth(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_action(in_action),
    .in_address(in_address), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_action(out_action),
    .out_address(out_address), .out_data(out_data),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: pops compared first, then any accepted push is recorded.
  always @(negedge clk) begin
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected: got %0d/%0h/%0h expected no entry",
                   out_action, out_address, out_data);
        end else begin
          if (out_action !== exp_q[0].a || out_address !== exp_q[0].addr ||
              out_data !== exp_q[0].data) begin
            errors++;
            $display("FAIL pop_head: got %0d/%0h/%0h expected %0d/%0h/%0h",
                     out_action, out_address, out_data,
                     exp_q[0].a, exp_q[0].addr, exp_q[0].data);
          end
          void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
`ifdef CASH_REQ_MERGE_EN
        if (exp_q.size() > 0 && in_action && exp_q[$].a && exp_q[$].addr == in_address)
          exp_q[$].data = in_data;
        else
          exp_q.push_back('{in_action, in_address, in_data});
`else
        exp_q.push_back('{in_action, in_address, in_data});
`endif
      end
    end
  end

  task automatic push(input logic a, input logic [3:0] addr, input logic [3:0] data);
    in_valid   = 1'b1;
    in_action  = a;
    in_address = addr;
    in_data    = data;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain;
    out_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (empty) break;
    end
    chk("drain_empty", int'(empty), 1);
    chk("drain_sb_left", exp_q.size(), 0);
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_action = 1'b0;
    in_address = '0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);

    // Fill with four writes, then drain in order
    @(posedge clk); #1;
    push(1, 4'h1, 4'hA); push(1, 4'h2, 4'hB); push(1, 4'h3, 4'hC); push(1, 4'h4, 4'hD);
    @(negedge clk);
    chk("fill_count", int'(count), 4);
    chk("fill_full", int'(full), 1);
    chk("fill_in_ready", int'(in_ready), 0);
    chk("fill_head_addr", int'(out_address), 1);
    chk("fill_head_data", int'(out_data), 10);
    drain();

    // Pointer wrap
    push(0, 4'h1, 4'h0); push(0, 4'h2, 4'h0); push(0, 4'h3, 4'h0);
    drain();
    push(1, 4'h5, 4'h1); push(1, 4'h6, 4'h2); push(1, 4'h7, 4'h3); push(1, 4'h8, 4'h4);
    @(negedge clk);
    chk("wrap_count4", int'(count), 4);
    chk("wrap_head", int'(out_address), 5);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("wrap_count_%0d", i), int'(count), 3 - i);
    end
    @(posedge clk); #1;
    chk("wrap_empty_ignored", int'(count), 0);
    out_ready = 1'b0;

    // Simultaneous push and pop at count 2
    push(0, 4'h3, 4'h1); push(0, 4'h4, 4'h2);
    in_valid = 1'b1; in_action = 1'b0; in_address = 4'h5; in_data = 4'h3;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("pp_count", int'(count), 2);
    chk("pp_head", int'(out_address), 4);
    drain();

    // Full with producer holding; one-cycle pop pulse
    push(1, 4'h1, 4'h5); push(1, 4'h2, 4'h6); push(1, 4'h3, 4'h7); push(1, 4'h4, 4'h8);
    in_valid = 1'b1; in_action = 1'b1; in_address = 4'hA; in_data = 4'h9;
    @(negedge clk);
    chk("hold_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("hold_count3", int'(count), 3);
    chk("hold_ready_again", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("hold_count4", int'(count), 4);
    drain();

    // Flush with an in-flight request
    push(0, 4'h1, 4'h1); push(0, 4'h2, 4'h2); push(0, 4'h3, 4'h3);
    in_valid = 1'b1; in_action = 1'b0; in_address = 4'hE; in_data = 4'hE;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_count", int'(count), 0);
    chk("flush_empty", int'(empty), 1);
    @(posedge clk); #1;
    push(0, 4'h6, 4'h6); push(0, 4'h7, 4'h7);
    @(negedge clk);
    chk("flush_head", int'(out_address), 6);
    drain();

    // Reset mid-burst
    push(0, 4'h1, 4'h1); push(0, 4'h2, 4'h2); push(0, 4'h3, 4'h3);
    in_valid = 1'b1; in_action = 1'b0; in_address = 4'hD; in_data = 4'hD;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rstb_count", int'(count), 0);
    chk("rstb_empty", int'(empty), 1);
    @(posedge clk); #1;
    push(1, 4'h2, 4'h5);
    @(negedge clk);
    chk("rstb_head_addr", int'(out_address), 2);
    chk("rstb_head_data", int'(out_data), 5);
    drain();

    // Repeated write to the same address
    push(1, 4'h9, 4'h3); push(1, 4'h9, 4'h7);
    @(negedge clk);
`ifdef CASH_REQ_MERGE_EN
    chk("merge_count", int'(count), 1);
    chk("merge_head_data", int'(out_data), 7);
`else
    chk("merge_count", int'(count), 2);
    chk("merge_head_data", int'(out_data), 3);
`endif
    chk("merge_head_addr", int'(out_address), 9);
    drain();

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
